mcdf_arbiter: RTL and testbench

- Downstream stage of the three per-channel slave FIFOs; feeds the packet formatter.
- Picks one requesting channel by register-programmed priority and reads one packet from it with the ack/val handshake.
- Forwards the packet words, tagged with channel id and start/end-of-packet markers.

---
 rtl/mcdf_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mcdf_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one requesting slave FIFO by programmed priority, reads one
// packet with the ack/val handshake and forwards it to the formatter with id/sop/eop tags.
module mcdf_arbiter #(
    parameter int DW   = 32,
    parameter int ID_W = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            slv0_req_i,
    input  logic            slv1_req_i,
    input  logic            slv2_req_i,
    input  logic            slv0_val_i,
    input  logic            slv1_val_i,
    input  logic            slv2_val_i,
    input  logic [DW-1:0]   slv0_data_i,
    input  logic [DW-1:0]   slv1_data_i,
    input  logic [DW-1:0]   slv2_data_i,
    input  logic [1:0]      slv0_prio_i,
    input  logic [1:0]      slv1_prio_i,
    input  logic [1:0]      slv2_prio_i,
    input  logic [1:0]      slv0_len_i,
    input  logic [1:0]      slv1_len_i,
    input  logic [1:0]      slv2_len_i,
    input  logic            f2a_rdy_i,
    output logic            a2s0_ack_o,
    output logic            a2s1_ack_o,
    output logic            a2s2_ack_o,
    output logic            a2f_val_o,
    output logic [DW-1:0]   a2f_data_o,
    output logic [ID_W-1:0] a2f_id_o,
    output logic            a2f_sop_o,
    output logic            a2f_eop_o,
    output logic [5:0]      a2f_len_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  req;
    logic [1:0]  prio     [3];
    logic [1:0]  len_code [3];
    logic [1:0]  sel;
    logic [2:0]  ack;
    logic [5:0]  ack_cnt;
    logic [5:0]  rx_cnt;

    logic        gnt_any;
    logic [1:0]  gnt_ch;
    logic [1:0]  best_prio;
    logic [5:0]  gnt_len;
    logic        sel_val;
    logic [DW-1:0] sel_data;

    assign req         = {slv2_req_i, slv1_req_i, slv0_req_i};
    assign prio[0]     = slv0_prio_i;
    assign prio[1]     = slv1_prio_i;
    assign prio[2]     = slv2_prio_i;
    assign len_code[0] = slv0_len_i;
    assign len_code[1] = slv1_len_i;
    assign len_code[2] = slv2_len_i;

    assign a2s0_ack_o = ack[0];
    assign a2s1_ack_o = ack[1];
    assign a2s2_ack_o = ack[2];

    // Strict '<' while scanning upward keeps ties on the lowest channel index.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_ch    = '0;
        best_prio = '1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (req[i] && (!gnt_any || prio[i] < best_prio)) begin
                gnt_any   = 1'b1;
                gnt_ch    = 2'(i);
                best_prio = prio[i];
            end
        end
        gnt_len = 6'd4 << len_code[gnt_ch];
    end

    always_comb begin
        sel_val  = 1'b0;
        sel_data = '0;
        case (sel)
            2'd0: begin sel_val = slv0_val_i; sel_data = slv0_data_i; end
            2'd1: begin sel_val = slv1_val_i; sel_data = slv1_data_i; end
            2'd2: begin sel_val = slv2_val_i; sel_data = slv2_data_i; end
            default: begin sel_val = 1'b0; sel_data = '0; end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            sel        <= '0;
            ack        <= '0;
            ack_cnt    <= '0;
            rx_cnt     <= '0;
            a2f_val_o  <= 1'b0;
            a2f_data_o <= '0;
            a2f_id_o   <= '0;
            a2f_sop_o  <= 1'b0;
            a2f_eop_o  <= 1'b0;
            a2f_len_o  <= '0;
            busy_o     <= 1'b0;
        end else begin
            a2f_val_o <= 1'b0;
            a2f_sop_o <= 1'b0;
            a2f_eop_o <= 1'b0;

            // Return path runs concurrently with XFER; words beyond len are dropped.
            if (state != IDLE && sel_val && rx_cnt != a2f_len_o) begin
                a2f_val_o  <= 1'b1;
                a2f_data_o <= sel_data;
                a2f_sop_o  <= (rx_cnt == 6'd0);
                a2f_eop_o  <= (rx_cnt == a2f_len_o - 6'd1);
                rx_cnt     <= rx_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (f2a_rdy_i && gnt_any) begin
                        state     <= XFER;
                        sel       <= gnt_ch;
                        a2f_len_o <= gnt_len;
                        a2f_id_o  <= ID_W'(gnt_ch);
                        ack_cnt   <= '0;
                        rx_cnt    <= '0;
                        ack       <= 3'b001 << gnt_ch;
                        busy_o    <= 1'b1;
                    end
                end
                XFER: begin
                    ack_cnt <= ack_cnt + 6'd1;
                    if (ack_cnt + 6'd1 == a2f_len_o) begin
                        ack   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (rx_cnt == a2f_len_o) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ack    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: a packet-level vector table plus hand-written
// sequences for backpressure, val gaps, reset mid-packet and mid-packet input changes.
module tb_mcdf_arbiter;

    localparam logic [31:0] BASE [3] = '{32'hA000_0001, 32'h0000_0011, 32'hC000_0001};

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [2:0]  req;
    logic [1:0]  p0, p1, p2, l0, l1, l2;
    logic        rdy;
    logic [2:0]  slv_val;
    logic [31:0] slv_data [3];
    logic        a2s0_ack_o, a2s1_ack_o, a2s2_ack_o;
    logic        a2f_val_o, a2f_sop_o, a2f_eop_o, busy_o;
    logic [31:0] a2f_data_o;
    logic [1:0]  a2f_id_o;
    logic [5:0]  a2f_len_o;
    logic [2:0]  ack;
    logic        stall;
    logic [2:0]  noise;

    assign ack = {a2s2_ack_o, a2s1_ack_o, a2s0_ack_o};

    mcdf_arbiter #(.DW(32), .ID_W(2)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
        .slv0_val_i(slv_val[0]), .slv1_val_i(slv_val[1]), .slv2_val_i(slv_val[2]),
        .slv0_data_i(slv_data[0]), .slv1_data_i(slv_data[1]), .slv2_data_i(slv_data[2]),
        .slv0_prio_i(p0), .slv1_prio_i(p1), .slv2_prio_i(p2),
        .slv0_len_i(l0), .slv1_len_i(l1), .slv2_len_i(l2),
        .f2a_rdy_i(rdy),
        .a2s0_ack_o(a2s0_ack_o), .a2s1_ack_o(a2s1_ack_o), .a2s2_ack_o(a2s2_ack_o),
        .a2f_val_o(a2f_val_o), .a2f_data_o(a2f_data_o), .a2f_id_o(a2f_id_o),
        .a2f_sop_o(a2f_sop_o), .a2f_eop_o(a2f_eop_o), .a2f_len_o(a2f_len_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Slave FIFO model: word for each ack appears one cycle later unless stalled.
    int pend [3] = '{0, 0, 0};
    int seq  [3] = '{0, 0, 0};
    always @(posedge clk_i) begin
        for (int c = 0; c < 3; c++) begin
            int p;
            int s;
            p = pend[c];
            s = seq[c];
            if (!rstn_i || !busy_o) begin
                p = 0;
                s = 0;
                slv_val[c]  <= noise[c];
                slv_data[c] <= 32'hDEAD_BEEF;
            end else begin
                p = p + (ack[c] ? 1 : 0);
                if (p > 0 && !stall) begin
                    slv_val[c]  <= 1'b1;
                    slv_data[c] <= BASE[c] + 32'(s);
                    s = s + 1;
                    p = p - 1;
                end else begin
                    slv_val[c]  <= noise[c];
                    slv_data[c] <= 32'hDEAD_BEEF;
                end
            end
            pend[c] <= p;
            seq[c]  <= s;
        end
    end

    // Monitor: ack totals and captured formatter words.
    int          ack_tot [3] = '{0, 0, 0};
    int          ack_start = 0;
    logic        prev_ack = 1'b0;
    int          wr_idx = 0;
    logic [31:0] w_data [512];
    logic [1:0]  w_id   [512];
    logic        w_sop  [512];
    logic        w_eop  [512];
    logic [5:0]  w_len  [512];
    int          w_cyc  [512];

    always @(negedge clk_i) begin
        for (int c = 0; c < 3; c++)
            if (ack[c] === 1'b1) ack_tot[c] <= ack_tot[c] + 1;
        if ((|ack) && !prev_ack) ack_start <= cyc;
        prev_ack <= |ack;
        if (a2f_val_o === 1'b1 && wr_idx < 512) begin
            w_data[wr_idx] <= a2f_data_o;
            w_id[wr_idx]   <= a2f_id_o;
            w_sop[wr_idx]  <= a2f_sop_o;
            w_eop[wr_idx]  <= a2f_eop_o;
            w_len[wr_idx]  <= a2f_len_o;
            w_cyc[wr_idx]  <= cyc;
            wr_idx         <= wr_idx + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int snap_wr = 0;
    int snap_ack [3] = '{0, 0, 0};

    typedef struct {
        logic [2:0] req;
        logic [1:0] p0, p1, p2;
        logic [1:0] l0, l1, l2;
        int         ch;
        int         len;
        string      name;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic [2:0] r, input logic [1:0] a0, input logic [1:0] a1,
                                input logic [1:0] a2, input logic [1:0] c0, input logic [1:0] c1,
                                input logic [1:0] c2, input int ch, input int len, input string nm);
        vec_t v;
        v.req = r; v.p0 = a0; v.p1 = a1; v.p2 = a2;
        v.l0 = c0; v.l1 = c1; v.l2 = c2;
        v.ch = ch; v.len = len; v.name = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic snap();
        snap_wr = wr_idx;
        for (int c = 0; c < 3; c++) snap_ack[c] = ack_tot[c];
    endtask

    task automatic wait_busy(input logic lvl, input int lim, input string nm);
        int n;
        n = 0;
        while (busy_o !== lvl && n < lim) begin
            step();
            n++;
        end
        chk(nm, longint'(busy_o), longint'(lvl));
    endtask

    task automatic check_pkt(input int ch, input int len, input string nm);
        int bad;
        int first;
        int nw;
        int oth;
        int idx;
        bad = 0;
        first = -1;
        nw = wr_idx - snap_wr;
        chk({nm, "_acks"}, ack_tot[ch] - snap_ack[ch], len);
        oth = 0;
        for (int c = 0; c < 3; c++)
            if (c != ch) oth += ack_tot[c] - snap_ack[c];
        chk({nm, "_other_acks"}, oth, 0);
        chk({nm, "_words"}, nw, len);
        for (int k = 0; k < nw; k++) begin
            idx = snap_wr + k;
            if (w_data[idx] !== BASE[ch] + 32'(k) || int'(w_id[idx]) != ch ||
                int'(w_len[idx]) != len || w_sop[idx] !== (k == 0) || w_eop[idx] !== (k == len - 1)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (bad != 0) $display("  first bad word index %0d in %s", first, nm);
        chk({nm, "_word_fields_bad"}, bad, 0);
    endtask

    task automatic wait_ack0(input int target, input int lim);
        int n;
        n = 0;
        while (ack_tot[0] - snap_ack[0] < target && n < lim) begin
            step();
            n++;
        end
    endtask

    initial begin
        rstn_i = 1'b0;
        req = '0; rdy = 1'b0; stall = 1'b0; noise = '0;
        p0 = '0; p1 = '0; p2 = '0; l0 = '0; l1 = '0; l2 = '0;

        vecs[0] = mk(3'b010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 4,  "single_ch1");
        vecs[1] = mk(3'b111, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2, 4,  "prio_first");
        vecs[2] = mk(3'b011, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1, 4,  "prio_second");
        vecs[3] = mk(3'b001, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 4,  "prio_third");
        vecs[4] = mk(3'b111, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 0, 8,  "eq_first");
        vecs[5] = mk(3'b110, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 1, 4,  "eq_second");
        vecs[6] = mk(3'b100, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2, 16, "eq_third");
        vecs[7] = mk(3'b111, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 1, 8,  "tie_subset");
        vecs[8] = mk(3'b001, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 0, 32, "max_len");
        vecs[9] = mk(3'b101, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 0, 16, "tie_ch0_ch2");

        repeat (3) step();
        chk("reset_ctrl_outputs", {a2s0_ack_o, a2s1_ack_o, a2s2_ack_o, a2f_val_o, a2f_sop_o,
                                   a2f_eop_o, busy_o, a2f_id_o, a2f_len_o}, 0);
        chk("reset_data_output", a2f_data_o, 0);
        rstn_i = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 10; i++) begin
            snap();
            req = vecs[i].req;
            p0 = vecs[i].p0; p1 = vecs[i].p1; p2 = vecs[i].p2;
            l0 = vecs[i].l0; l1 = vecs[i].l1; l2 = vecs[i].l2;
            rdy = 1'b1;
            wait_busy(1'b1, 20, {vecs[i].name, "_grant"});
            rdy = 1'b0;
            req = '0;
            wait_busy(1'b0, 200, {vecs[i].name, "_done"});
            check_pkt(vecs[i].ch, vecs[i].len, vecs[i].name);
            if (i == 0) chk("first_val_latency", w_cyc[snap_wr] - ack_start, 2);
            step();
        end

        // Backpressure: request pending while formatter not ready.
        snap();
        req = 3'b001; p0 = 2'd0; l0 = 2'd0; rdy = 1'b0;
        repeat (5) step();
        chk("bp_busy_low", busy_o, 0);
        chk("bp_no_ack", ack_tot[0] - snap_ack[0], 0);
        rdy = 1'b1;
        step();
        chk("bp_grant_next_cycle", a2s0_ack_o, 1);
        rdy = 1'b0;
        req = '0;
        wait_busy(1'b0, 200, "bp_done");
        check_pkt(0, 4, "bp_pkt");
        step();

        // Slave val gap plus stray val on the unselected channels.
        snap();
        req = 3'b100; p2 = 2'd0; l2 = 2'd1; rdy = 1'b1;
        wait_busy(1'b1, 20, "gap_grant");
        rdy = 1'b0;
        req = '0;
        noise = 3'b011;
        repeat (2) step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        chk("gap_still_busy", busy_o, 1);
        noise = '0;
        wait_busy(1'b0, 200, "gap_done");
        check_pkt(2, 8, "gap");
        step();

        // Reset asserted during the third ack of an 8-word packet.
        snap();
        req = 3'b001; p0 = 2'd0; l0 = 2'd1; rdy = 1'b1;
        wait_busy(1'b1, 20, "rst_grant");
        rdy = 1'b0;
        wait_ack0(3, 20);
        chk("rst_third_ack_seen", ack_tot[0] - snap_ack[0], 3);
        rstn_i = 1'b0;
        #1;
        chk("rst_outputs_cleared", {a2s0_ack_o, a2s1_ack_o, a2s2_ack_o, a2f_val_o, a2f_sop_o,
                                    a2f_eop_o, busy_o, a2f_id_o, a2f_len_o}, 0);
        chk("rst_data_cleared", a2f_data_o, 0);
        repeat (2) step();
        chk("rst_no_ack_in_reset", ack, 0);
        snap();
        rdy = 1'b1;
        rstn_i = 1'b1;
        wait_busy(1'b1, 20, "rst_regrant");
        rdy = 1'b0;
        req = '0;
        wait_busy(1'b0, 200, "rst_done");
        check_pkt(0, 8, "rst_restart");
        step();

        // Inputs of the selected channel change mid-packet; formatter stays ready.
        snap();
        req = 3'b010; p1 = 2'd0; l1 = 2'd0; p0 = 2'd3; l0 = 2'd0; rdy = 1'b1;
        wait_busy(1'b1, 20, "mid_grant");
        step();
        req = 3'b001;
        p1 = 2'd2;
        l1 = 2'd1;
        step();
        req = 3'b011;
        wait_busy(1'b0, 200, "mid_done");
        check_pkt(1, 4, "mid_current");
        snap();
        wait_busy(1'b1, 20, "mid_next_grant");
        rdy = 1'b0;
        req = '0;
        wait_busy(1'b0, 200, "mid_next_done");
        check_pkt(1, 8, "mid_next");
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "watchdog");
    end

endmodule
